// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS I/O port: datapath width, IN/OUT decode
// constants, and the output-stage state encoding.
// No ports; imported by the interface, the FIFO and the top.
package mips_io_pkg;

    localparam int IO_DATA_W = 16;

    // IN and OUT share one opcode and are distinguished by the funk field.
    localparam logic [3:0] OP_IO    = 4'b1100;
    localparam logic [2:0] FUNK_IN  = 3'b000;
    localparam logic [2:0] FUNK_OUT = 3'b001;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_t;

endpackage

// File: rtl/mips_io_port_if.sv
// Bundle of control-unit strobes, IN data/stall and both external channels.
// slave: the I/O port side; master: control unit plus external world.
// Widths follow DATA_W and IN_DEPTH so InCount can hold 0..IN_DEPTH.
interface mips_io_port_if
    import mips_io_pkg::*;
#(
    parameter int DATA_W   = IO_DATA_W,
    parameter int IN_DEPTH = 4
);

    logic                        InputRead;
    logic                        OutputWrite;
    logic [DATA_W-1:0]           OutData;
    logic [DATA_W-1:0]           InData;
    logic                        IOStall;
    logic [$clog2(IN_DEPTH):0]   InCount;
    logic [DATA_W-1:0]           ext_in_data;
    logic                        ext_in_valid;
    logic                        ext_in_ready;
    logic [DATA_W-1:0]           ext_out_data;
    logic                        ext_out_valid;
    logic                        ext_out_ready;

    modport slave (
        input  InputRead, OutputWrite, OutData,
        input  ext_in_data, ext_in_valid, ext_out_ready,
        output InData, IOStall, InCount,
        output ext_in_ready, ext_out_data, ext_out_valid
    );

    modport master (
        output InputRead, OutputWrite, OutData,
        output ext_in_data, ext_in_valid, ext_out_ready,
        input  InData, IOStall, InCount,
        input  ext_in_ready, ext_out_data, ext_out_valid
    );

endinterface

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with a show-ahead head word (0 when empty).
// Latency: a pushed word is visible at head one cycle later; no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: CLK/Reset, push + wr_data, pop, head, full, empty, count (0..DEPTH).
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module io_sync_fifo
    import mips_io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];
    assign count   = cnt;

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mips_io_port.sv
// I/O port for the multicycle MIPS: buffered IN channel, one-word OUT stage.
// Latency: ext push -> InData 1 cycle; OutputWrite -> ext_out_valid 1 cycle.
// Backpressure: IOStall when IN finds the FIFO empty or OUT finds the stage
// full and not being drained; ext_in_ready drops when the FIFO is full.
// Ports: CLK, Reset (async active-low), io (slave side of mips_io_port_if).
module mips_io_port
    import mips_io_pkg::*;
#(
    parameter int DATA_W   = IO_DATA_W,
    parameter int IN_DEPTH = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    mips_io_port_if.slave  io
);

    // ---------------- input side ----------------
    logic in_full;
    logic in_empty;
    logic in_push;
    logic in_pop;
    logic in_stall;
    logic ready_en;

    // Holds ext_in_ready low through reset; rises on the first edge after
    // release so no word is accepted before the port is running.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Ready comes from registered occupancy only: a pop in the same cycle
    // does not reopen a full FIFO.
    assign io.ext_in_ready = ready_en && !in_full;
    assign in_push         = io.ext_in_valid && io.ext_in_ready;
    assign in_pop          = io.InputRead && !in_empty;
    assign in_stall        = io.InputRead && in_empty;

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .CLK     (CLK),
        .Reset   (Reset),
        .push    (in_push),
        .wr_data (io.ext_in_data),
        .pop     (in_pop),
        .head    (io.InData),
        .full    (in_full),
        .empty   (in_empty),
        .count   (io.InCount)
    );

    // ---------------- output side ----------------
    out_state_t        state;
    out_state_t        state_nxt;
    logic              out_load;
    logic              out_stall;
    logic [DATA_W-1:0] out_dat;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= OUT_IDLE;
            out_dat <= '0;
        end else begin
            state <= state_nxt;
            if (out_load) begin
                out_dat <= io.OutData;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        out_load  = 1'b0;
        out_stall = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (io.OutputWrite) begin
                    out_load  = 1'b1;
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (io.ext_out_ready) begin
                    // Word drains this edge; a new OUT can refill behind it.
                    if (io.OutputWrite) begin
                        out_load = 1'b1;
                    end else begin
                        state_nxt = OUT_IDLE;
                    end
                end else if (io.OutputWrite) begin
                    out_stall = 1'b1;
                end
            end
            default: state_nxt = OUT_IDLE;
        endcase
    end

    assign io.ext_out_valid = (state == OUT_FULL);
    assign io.ext_out_data  = out_dat;

    // IN and OUT are independent; either one holds the control unit.
    assign io.IOStall = in_stall || out_stall;

endmodule

// File: tb/tb_mips_io_port.sv
module tb_mips_io_port;
    import mips_io_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic CLK = 1'b1;
    logic Reset;

    mips_io_port_if #(.DATA_W(DW), .IN_DEPTH(DEPTH)) bus ();

    mips_io_port #(.DATA_W(DW), .IN_DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .io    (bus)
    );

    // Rising edges at 10, 20, 30 ... ns; reset release at 15 ns is mid-cycle.
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] in_q[$];
    logic [15:0] out_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at rising edge + 1. Drives one cycle of stimulus, checks the
    // combinational and registered outputs mid-cycle against the queue model,
    // updates the model for what the coming edge should do, then advances.
    task automatic cycle(input logic iv, input logic [15:0] id, input logic ir,
                         input logic ow, input logic [15:0] od, input logic ordy);
        logic        exp_rdy;
        logic        exp_stall;
        logic        m_empty;
        logic        m_out_full;
        logic [15:0] exp_dat;
        bus.ext_in_valid  = iv;
        bus.ext_in_data   = id;
        bus.InputRead     = ir;
        bus.OutputWrite   = ow;
        bus.OutData       = od;
        bus.ext_out_ready = ordy;
        #3;
        exp_rdy    = (in_q.size() < DEPTH);
        m_empty    = (in_q.size() == 0);
        m_out_full = (out_q.size() != 0);
        exp_stall  = (ir && m_empty) || (ow && m_out_full && !ordy);
        exp_dat    = m_empty ? 16'h0000 : in_q[0];
        check("in_ready",  32'(bus.ext_in_ready),  32'(exp_rdy));
        check("in_count",  32'(bus.InCount),       32'(in_q.size()));
        check("io_stall",  32'(bus.IOStall),       32'(exp_stall));
        check("in_data",   32'(bus.InData),        32'(exp_dat));
        check("out_valid", 32'(bus.ext_out_valid), 32'(m_out_full));
        if (ir && !m_empty) void'(in_q.pop_front());
        if (m_out_full) begin
            check("out_data", 32'(bus.ext_out_data), 32'(out_q[0]));
            if (ordy) void'(out_q.pop_front());
        end
        if (ow && !(m_out_full && !ordy)) out_q.push_back(od);
        if (iv && exp_rdy) in_q.push_back(id);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] pw [4];
        pw[0] = 16'h00A1;
        pw[1] = 16'h00B2;
        pw[2] = 16'h00C3;
        pw[3] = 16'h00D4;

        Reset             = 1'b0;
        bus.InputRead     = 1'b0;
        bus.OutputWrite   = 1'b0;
        bus.OutData       = '0;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.ext_out_ready = 1'b0;

        // Reset values, sampled after an edge with reset still low.
        #12;
        check("rst_in_data",   32'(bus.InData),        32'h0);
        check("rst_stall",     32'(bus.IOStall),       32'h0);
        check("rst_count",     32'(bus.InCount),       32'h0);
        check("rst_in_ready",  32'(bus.ext_in_ready),  32'h0);
        check("rst_out_valid", 32'(bus.ext_out_valid), 32'h0);
        check("rst_out_data",  32'(bus.ext_out_data),  32'h0);
        #3;
        Reset = 1'b1;
        #2;
        check("rdy_before_edge", 32'(bus.ext_in_ready), 32'h0);
        @(posedge CLK);
        #1;
        check("rdy_after_rst", 32'(bus.ext_in_ready), 32'h1);

        // Fill the FIFO, then offer a fifth word that must be refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, pw[i], 1'b0, 1'b0, 16'h0, 1'b0);
        check("count_full", 32'(bus.InCount), 32'd4);
        cycle(1'b1, 16'hEEEE, 1'b0, 1'b0, 16'h0, 1'b0);

        // Drain: first read offers a word while full (no same-cycle refill).
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("count_drained", 32'(bus.InCount), 32'd0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

        // Empty FIFO: push and read together stalls, word shows next cycle.
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

        // Output stage: load, stall while blocked, refill on drain, empty.
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        check("out_beef", 32'(bus.ext_out_data), 32'h0000BEEF);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'hCAFE, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'hCAFE, 1'b1);
        check("out_cafe", 32'(bus.ext_out_data), 32'h0000CAFE);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Pointer wrap: prime one word, then simultaneous push/pop pairs.
        cycle(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i < 10; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

        // Reset with a word in the output stage and one in the FIFO.
        cycle(1'b1, 16'h7777, 1'b0, 1'b1, 16'h5A5A, 1'b0);
        check("pre_rst_valid", 32'(bus.ext_out_valid), 32'h1);
        bus.ext_in_valid = 1'b0;
        bus.OutputWrite  = 1'b0;
        #1;
        Reset = 1'b0;
        #1;
        check("async_out_valid", 32'(bus.ext_out_valid), 32'h0);
        check("async_count",     32'(bus.InCount),       32'h0);
        check("async_in_data",   32'(bus.InData),        32'h0);
        check("async_in_ready",  32'(bus.ext_in_ready),  32'h0);
        in_q.delete();
        out_q.delete();
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check("rerst_in_ready",  32'(bus.ext_in_ready),  32'h1);
        check("rerst_out_valid", 32'(bus.ext_out_valid), 32'h0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
